// File: rtl/percept_loader.sv
// Byte-frame command parser feeding the perceptron array: indexed weight/input writes, broadcast input sweep, run.
// Optional trailing XOR checksum per frame when PERCEPT_LOADER_CSUM_EN is defined.
module percept_loader #(
    parameter int N_PERCEPT = 256,
    parameter int IDX_W     = 8,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              recieved,
    input  logic [7:0]        data_rx,
    output logic              wr_weight,
    output logic              wr_in,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic              run,
    output logic              busy,
    output logic              frame_err
);
    localparam int               TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PERCEPT - 1);
    localparam logic [7:0]       CMD_WEIGHT = 8'hA1;
    localparam logic [7:0]       CMD_INPUT  = 8'hA2;
    localparam logic [7:0]       CMD_BCAST  = 8'hA3;
    localparam logic [7:0]       CMD_RUN    = 8'hA5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_IDX  = 3'd1,
        GET_DATA = 3'd2,
        SWEEP    = 3'd3,
        GET_CSUM = 3'd4
    } state_t;

    state_t              r_state, w_state, w_act_state;
    logic [7:0]          r_cmd, w_cmd;
    logic [7:0]          r_idx, w_idx;
    logic [TMO_W-1:0]    r_tmo, w_tmo;
    logic [IDX_W-1:0]    r_sweep, w_sweep;
    logic                r_wr_weight, w_wr_weight;
    logic                r_wr_in, w_wr_in;
    logic [IDX_W-1:0]    r_wr_idx, w_wr_idx, w_act_idx;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data;
    logic                r_run, w_run;
    logic                r_busy, w_busy;
    logic                r_frame_err, w_frame_err;
    logic                w_fire, w_idx_ok;
    logic                w_act_ww, w_act_wi, w_act_run, w_act_err;
    logic [7:0]          w_act_data;
`ifdef PERCEPT_LOADER_CSUM_EN
    logic [7:0]          r_data, w_data;
    logic [7:0]          r_csum, w_csum;
    assign w_act_data = r_data;
`else
    assign w_act_data = data_rx;
`endif

    assign w_idx_ok = (32'(r_idx) < 32'(N_PERCEPT));

    // Action a completed frame requests, decoded from the latched command.
    always_comb begin
        w_act_state = IDLE;
        w_act_ww    = 1'b0;
        w_act_wi    = 1'b0;
        w_act_run   = 1'b0;
        w_act_err   = 1'b0;
        w_act_idx   = IDX_W'(r_idx);
        case (r_cmd)
            CMD_WEIGHT: begin
                w_act_ww  = w_idx_ok;
                w_act_err = ~w_idx_ok;
            end
            CMD_INPUT: begin
                w_act_wi  = w_idx_ok;
                w_act_err = ~w_idx_ok;
            end
            CMD_BCAST: begin
                w_act_wi    = 1'b1;
                w_act_idx   = {IDX_W{1'b0}};
                w_act_state = SWEEP;
            end
            CMD_RUN:   w_act_run = 1'b1;
            default:   w_act_err = 1'b1;
        endcase
    end

    // Parser next-state and next-output logic.
    always_comb begin
        w_state     = r_state;
        w_cmd       = r_cmd;
        w_idx       = r_idx;
        w_tmo       = r_tmo;
        w_sweep     = r_sweep;
        w_wr_weight = 1'b0;
        w_wr_in     = 1'b0;
        w_run       = 1'b0;
        w_frame_err = 1'b0;
        w_wr_idx    = r_wr_idx;
        w_wr_data   = r_wr_data;
        w_fire      = 1'b0;
`ifdef PERCEPT_LOADER_CSUM_EN
        w_data      = r_data;
        w_csum      = r_csum;
`endif
        case (r_state)
            IDLE: begin
                w_tmo = {TMO_W{1'b0}};
                if (recieved) begin
                    w_cmd = data_rx;
`ifdef PERCEPT_LOADER_CSUM_EN
                    w_csum = data_rx;
`endif
                    case (data_rx)
                        CMD_WEIGHT, CMD_INPUT: w_state = GET_IDX;
                        CMD_BCAST:             w_state = GET_DATA;
`ifdef PERCEPT_LOADER_CSUM_EN
                        CMD_RUN:               w_state = GET_CSUM;
`else
                        CMD_RUN:               w_run = 1'b1;
`endif
                        default:               w_frame_err = 1'b1;
                    endcase
                end else begin
                    w_cmd = r_cmd;
                end
            end
            GET_IDX, GET_DATA, GET_CSUM: begin
                if (recieved) begin
                    w_tmo = {TMO_W{1'b0}};
`ifdef PERCEPT_LOADER_CSUM_EN
                    w_csum = r_csum ^ data_rx;
`endif
                    if (r_state == GET_IDX) begin
                        w_idx   = data_rx;
                        w_state = GET_DATA;
                    end else if (r_state == GET_DATA) begin
`ifdef PERCEPT_LOADER_CSUM_EN
                        w_data  = data_rx;
                        w_state = GET_CSUM;
`else
                        w_fire  = 1'b1;
`endif
                    end else begin
`ifdef PERCEPT_LOADER_CSUM_EN
                        if (data_rx == r_csum) begin
                            w_fire = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                            w_state     = IDLE;
                        end
`else
                        w_state = IDLE;
`endif
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_frame_err = 1'b1;
                    w_state     = IDLE;
                    w_tmo       = {TMO_W{1'b0}};
                end else begin
                    w_tmo = r_tmo + TMO_W'(1);
                end
            end
            SWEEP: begin
                // A byte arriving mid-sweep is dropped; the sweep itself carries on.
                w_frame_err = recieved;
                if (r_sweep == LAST_IDX) begin
                    w_state = IDLE;
                end else begin
                    w_sweep  = r_sweep + IDX_W'(1);
                    w_wr_in  = 1'b1;
                    w_wr_idx = r_sweep + IDX_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase

        w_state     = w_fire ? w_act_state : w_state;
        w_wr_weight = w_wr_weight | (w_fire & w_act_ww);
        w_wr_in     = w_wr_in | (w_fire & w_act_wi);
        w_run       = w_run | (w_fire & w_act_run);
        w_frame_err = w_frame_err | (w_fire & w_act_err);
        w_wr_idx    = (w_fire & (w_act_ww | w_act_wi)) ? w_act_idx : w_wr_idx;
        w_wr_data   = (w_fire & (w_act_ww | w_act_wi)) ? DATA_W'(w_act_data) : w_wr_data;
        w_sweep     = w_fire ? {IDX_W{1'b0}} : w_sweep;
        w_busy      = (w_state != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_cmd       <= 8'h00;
            r_idx       <= 8'h00;
            r_tmo       <= {TMO_W{1'b0}};
            r_sweep     <= {IDX_W{1'b0}};
            r_wr_weight <= 1'b0;
            r_wr_in     <= 1'b0;
            r_wr_idx    <= {IDX_W{1'b0}};
            r_wr_data   <= {DATA_W{1'b0}};
            r_run       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PERCEPT_LOADER_CSUM_EN
            r_data      <= 8'h00;
            r_csum      <= 8'h00;
`endif
        end else begin
            r_state     <= w_state;
            r_cmd       <= w_cmd;
            r_idx       <= w_idx;
            r_tmo       <= w_tmo;
            r_sweep     <= w_sweep;
            r_wr_weight <= w_wr_weight;
            r_wr_in     <= w_wr_in;
            r_wr_idx    <= w_wr_idx;
            r_wr_data   <= w_wr_data;
            r_run       <= w_run;
            r_busy      <= w_busy;
            r_frame_err <= w_frame_err;
`ifdef PERCEPT_LOADER_CSUM_EN
            r_data      <= w_data;
            r_csum      <= w_csum;
`endif
        end
    end

    assign wr_weight = r_wr_weight;
    assign wr_in     = r_wr_in;
    assign wr_idx    = r_wr_idx;
    assign wr_data   = r_wr_data;
    assign run       = r_run;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_percept_loader.sv
// Bench for percept_loader: two instances (256 and 16 percepts) share one byte stream;
// a frame-level model predicts every output each cycle, plus directed literal checks.
module tb_percept_loader;
    localparam int TMO = 40;
    localparam int NP0 = 256;
    localparam int NP1 = 16;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rec = 1'b0;
    logic [7:0] drx = 8'h00;

    logic       o_ww [2];
    logic       o_wi [2];
    logic [7:0] o_idx [2];
    logic [7:0] o_dat [2];
    logic       o_run [2];
    logic       o_busy [2];
    logic       o_err [2];

    int n_chk = 0;
    int n_fail = 0;

    // model state: bytes of the frame so far, sweep progress, silence length
    logic [7:0] fb [2][3];
    int         fn [2];
    int         sw_left [2];
    int         sw_idx [2];
    logic [7:0] sw_dat [2];
    int         silent [2];
    logic       e_ww [2], e_wi [2], e_run [2], e_err [2], e_busy [2];
    logic [7:0] e_idx [2], e_dat [2];

    percept_loader #(.N_PERCEPT(NP0), .IDX_W(8), .DATA_W(8), .TIMEOUT(TMO)) u_dut0 (
        .clk(clk), .nRst(nRst), .recieved(rec), .data_rx(drx),
        .wr_weight(o_ww[0]), .wr_in(o_wi[0]), .wr_idx(o_idx[0]), .wr_data(o_dat[0]),
        .run(o_run[0]), .busy(o_busy[0]), .frame_err(o_err[0])
    );

    percept_loader #(.N_PERCEPT(NP1), .IDX_W(8), .DATA_W(8), .TIMEOUT(TMO)) u_dut1 (
        .clk(clk), .nRst(nRst), .recieved(rec), .data_rx(drx),
        .wr_weight(o_ww[1]), .wr_in(o_wi[1]), .wr_idx(o_idx[1]), .wr_data(o_dat[1]),
        .run(o_run[1]), .busy(o_busy[1]), .frame_err(o_err[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        fn[k] = 0; sw_left[k] = 0; sw_idx[k] = 0; sw_dat[k] = 8'h00; silent[k] = 0;
        e_ww[k] = 1'b0; e_wi[k] = 1'b0; e_run[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
        e_idx[k] = 8'h00; e_dat[k] = 8'h00;
    endtask

    // Predict the outputs after the coming clock edge from the bytes seen so far.
    task automatic model_step(input int k, input int np);
        logic [7:0] c;
        e_ww[k] = 1'b0; e_wi[k] = 1'b0; e_run[k] = 1'b0; e_err[k] = 1'b0;
        if (sw_left[k] > 0) begin
            if (sw_left[k] > 1) begin
                e_wi[k] = 1'b1; e_idx[k] = 8'(sw_idx[k]); e_dat[k] = sw_dat[k];
                sw_idx[k]++;
            end
            if (rec) e_err[k] = 1'b1;
            sw_left[k]--;
        end else if (rec) begin
            silent[k] = 0;
            fb[k][fn[k]] = drx;
            fn[k]++;
            c = fb[k][0];
            if (fn[k] == 1) begin
                if (c == 8'hA5) begin
                    e_run[k] = 1'b1; fn[k] = 0;
                end else if (c != 8'hA1 && c != 8'hA2 && c != 8'hA3) begin
                    e_err[k] = 1'b1; fn[k] = 0;
                end
            end else if (c == 8'hA3) begin
                e_wi[k] = 1'b1; e_idx[k] = 8'h00; e_dat[k] = fb[k][1];
                sw_left[k] = np; sw_idx[k] = 1; sw_dat[k] = fb[k][1]; fn[k] = 0;
            end else if (fn[k] == 3) begin
                if (int'(fb[k][1]) < np) begin
                    e_ww[k] = (c == 8'hA1); e_wi[k] = (c == 8'hA2);
                    e_idx[k] = fb[k][1]; e_dat[k] = fb[k][2];
                end else begin
                    e_err[k] = 1'b1;
                end
                fn[k] = 0;
            end
        end else if (fn[k] > 0) begin
            silent[k]++;
            if (silent[k] == TMO) begin
                e_err[k] = 1'b1; fn[k] = 0;
            end
        end
        e_busy[k] = (fn[k] > 0) || (sw_left[k] > 0);
    endtask

    // Compare process: check outputs against the model every cycle, then advance the model.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!nRst) model_reset(k);
                chk($sformatf("wr_weight[%0d]", k), 32'(o_ww[k]), 32'(e_ww[k]));
                chk($sformatf("wr_in[%0d]", k), 32'(o_wi[k]), 32'(e_wi[k]));
                chk($sformatf("run[%0d]", k), 32'(o_run[k]), 32'(e_run[k]));
                chk($sformatf("frame_err[%0d]", k), 32'(o_err[k]), 32'(e_err[k]));
                chk($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(e_busy[k]));
                if (e_ww[k] || e_wi[k] || !nRst) begin
                    chk($sformatf("wr_idx[%0d]", k), 32'(o_idx[k]), 32'(e_idx[k]));
                    chk($sformatf("wr_data[%0d]", k), 32'(o_dat[k]), 32'(e_dat[k]));
                end
            end
            if (nRst) begin
                model_step(0, NP0);
                model_step(1, NP1);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rec = 1'b1; drx = b;
        @(posedge clk); #1;
        rec = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0;
        #12;
        chk("reset busy", 32'(o_busy[0]), 32'd0);
        chk("reset wr_idx", 32'(o_idx[0]), 32'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        idle(2);

        // indexed weight write, spaced bytes
        send(8'hA1); chk("A1 busy", 32'(o_busy[0]), 32'd1);
        idle(3);
        send(8'h05); idle(2);
        send(8'h3C);
        chk("A1 wr_weight", 32'(o_ww[0]), 32'd1);
        chk("A1 wr_idx", 32'(o_idx[0]), 32'h05);
        chk("A1 wr_data", 32'(o_dat[0]), 32'h3C);
        chk("A1 busy after", 32'(o_busy[0]), 32'd0);
        idle(1);
        chk("A1 one pulse", 32'(o_ww[0]), 32'd0);

        // input write at top index; out of range for 16 percepts
        send(8'hA2); send(8'hFF); send(8'h80);
        chk("A2 wr_in", 32'(o_wi[0]), 32'd1);
        chk("A2 wr_idx", 32'(o_idx[0]), 32'hFF);
        chk("A2 wr_data", 32'(o_dat[0]), 32'h80);
        chk("A2 N16 frame_err", 32'(o_err[1]), 32'd1);
        chk("A2 N16 no wr_in", 32'(o_wi[1]), 32'd0);
        idle(2);
        send(8'hA2); send(8'h10); send(8'h44);
        chk("A2 idx16 N16 frame_err", 32'(o_err[1]), 32'd1);
        chk("A2 idx16 N256 wr_in", 32'(o_wi[0]), 32'd1);
        idle(2);

        // broadcast sweep with a byte injected mid-sweep
        send(8'hA3); send(8'h7E);
        chk("sweep first wr_in", 32'(o_wi[0]), 32'd1);
        chk("sweep first idx", 32'(o_idx[0]), 32'd0);
        chk("sweep data", 32'(o_dat[0]), 32'h7E);
        idle(99);
        send(8'h55);
        chk("sweep overrun err", 32'(o_err[0]), 32'd1);
        chk("sweep overrun wr_in", 32'(o_wi[0]), 32'd1);
        chk("sweep overrun idx", 32'(o_idx[0]), 32'd100);
        idle(155);
        chk("sweep last idx", 32'(o_idx[0]), 32'd255);
        chk("sweep last wr_in", 32'(o_wi[0]), 32'd1);
        idle(1);
        chk("sweep done wr_in", 32'(o_wi[0]), 32'd0);
        chk("sweep done busy", 32'(o_busy[0]), 32'd0);
        idle(2);

        // run and unknown command
        send(8'hA5);
        chk("run pulse", 32'(o_run[0]), 32'd1);
        idle(1);
        chk("run single", 32'(o_run[0]), 32'd0);
        send(8'h42);
        chk("bad cmd err", 32'(o_err[0]), 32'd1);
        chk("bad cmd busy", 32'(o_busy[0]), 32'd0);
        idle(2);

        // timeout then recovery
        send(8'hA1); send(8'h03);
        idle(TMO - 1);
        chk("tmo not yet err", 32'(o_err[0]), 32'd0);
        chk("tmo not yet busy", 32'(o_busy[0]), 32'd1);
        idle(1);
        chk("tmo err", 32'(o_err[0]), 32'd1);
        chk("tmo busy", 32'(o_busy[0]), 32'd0);
        idle(1);
        send(8'hA1); send(8'h03); send(8'h11);
        chk("post tmo wr_weight", 32'(o_ww[0]), 32'd1);
        chk("post tmo wr_idx", 32'(o_idx[0]), 32'h03);
        chk("post tmo wr_data", 32'(o_dat[0]), 32'h11);
        idle(2);

        // asynchronous reset mid-sweep
        send(8'hA3); send(8'h5A);
        idle(20);
        #2;
        nRst = 1'b0;
        #1;
        chk("rst wr_in", 32'(o_wi[0]), 32'd0);
        chk("rst busy", 32'(o_busy[0]), 32'd0);
        chk("rst wr_idx", 32'(o_idx[0]), 32'd0);
        chk("rst wr_data", 32'(o_dat[0]), 32'd0);
        @(posedge clk); #1;
        idle(2);
        nRst = 1'b1;
        idle(5);
        chk("post rst no strobe", 32'(o_wi[0]), 32'd0);
        send(8'hA2); send(8'h07); send(8'h99);
        chk("post rst wr_in", 32'(o_wi[0]), 32'd1);
        chk("post rst wr_idx", 32'(o_idx[0]), 32'h07);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
